// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, field positions and ID/EX record for the decode stage
package decode_pkg;

   localparam int REG_COUNT  = 16;
   localparam int DATA_WIDTH = 32;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 28;
   localparam int REGA_MSB   = 27;
   localparam int REGA_LSB   = 24;
   localparam int REGB_MSB   = 23;
   localparam int REGB_LSB   = 20;
   localparam int REGC_MSB   = 19;
   localparam int REGC_LSB   = 16;
   localparam int IMM_MSB    = 19;
   localparam int IMM_LSB    = 0;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_ALU   = 4'd1,
      OP_ADDI  = 4'd2,
      OP_LOAD  = 4'd3,
      OP_BEQ   = 4'd4,
      OP_JMP   = 4'd5,
      OP_STORE = 4'd6
   } opcode_e;

   typedef struct packed {
      logic [3:0]            opcode;
      logic [3:0]            destReg;
      logic [DATA_WIDTH-1:0] operandA;
      logic [DATA_WIDTH-1:0] operandB;
      logic [DATA_WIDTH-1:0] immediate;
      logic                  regWrite;
      logic                  memRead;
      logic                  memWrite;
   } idex_t;

   localparam idex_t BUBBLE = '0;

   function automatic logic [DATA_WIDTH-1:0] signExtendImm(input logic [19:0] imm);
      return {{12{imm[19]}}, imm};
   endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 16x32 register file, three read ports, one write port, write-through
module register_file
   import decode_pkg::*;
(
   input  logic                  ClockInput,
   input  logic                  ResetN,
   input  logic [3:0]            ReadAddrB,
   input  logic [3:0]            ReadAddrC,
   input  logic [3:0]            ReadAddrA,
   output logic [DATA_WIDTH-1:0] ReadDataB,
   output logic [DATA_WIDTH-1:0] ReadDataC,
   output logic [DATA_WIDTH-1:0] ReadDataA,
   input  logic                  WriteEnable,
   input  logic [3:0]            WriteAddr,
   input  logic [DATA_WIDTH-1:0] WriteData
);

   logic [DATA_WIDTH-1:0] regs [REG_COUNT];

   always_ff @(posedge ClockInput or negedge ResetN) begin
      if (!ResetN) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (WriteEnable && (WriteAddr != 4'd0)) begin
         regs[WriteAddr] <= WriteData;
      end
   end

   // R0 is hardwired to zero; a same-cycle write bypasses the array so decode sees it now.
   function automatic logic [DATA_WIDTH-1:0] readPort(input logic [3:0] addr);
      if (addr == 4'd0) begin
         return '0;
      end else if (WriteEnable && (WriteAddr == addr)) begin
         return WriteData;
      end else begin
         return regs[addr];
      end
   endfunction

   always_comb begin
      ReadDataB = readPort(ReadAddrB);
      ReadDataC = readPort(ReadAddrC);
      ReadDataA = readPort(ReadAddrA);
   end

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - decode, register read, branch resolve, hazard detect, ID/EX register
module instruction_decode_stage
   import decode_pkg::*;
(
   input  logic        ClockInput,
   input  logic        ResetN,
   input  logic [31:0] InstructionFetched,
   input  logic [31:0] ProgramCounter,
   input  logic        WB_WriteEnable,
   input  logic [3:0]  WB_WriteReg,
   input  logic [31:0] WB_WriteData,
   input  logic        EX_RegWrite,
   input  logic        EX_MemRead,
   input  logic [3:0]  EX_DestReg,
   input  logic        MEM_RegWrite,
   input  logic [3:0]  MEM_DestReg,
   output logic        BranchSelection,
   output logic [31:0] BranchAddress,
   output logic        IF_StallReq,
   output logic [3:0]  ID_Opcode,
   output logic [3:0]  ID_DestReg,
   output logic [31:0] ID_OperandA,
   output logic [31:0] ID_OperandB,
   output logic [31:0] ID_Immediate,
   output logic        ID_RegWrite,
   output logic        ID_MemRead,
   output logic        ID_MemWrite
);

   logic [3:0]  opcode;
   logic [3:0]  regA;
   logic [3:0]  regB;
   logic [3:0]  regC;
   logic [31:0] immediate;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [31:0] dataC;
   logic        useA;
   logic        useB;
   logic        useC;
   logic        loadUseStall;
   logic        branchStall;
   logic        stall;
   logic        branchTaken;
   idex_t       nextIdex;
   idex_t       idexQ;

   assign opcode    = InstructionFetched[OPCODE_MSB:OPCODE_LSB];
   assign regA      = InstructionFetched[REGA_MSB:REGA_LSB];
   assign regB      = InstructionFetched[REGB_MSB:REGB_LSB];
   assign regC      = InstructionFetched[REGC_MSB:REGC_LSB];
   assign immediate = signExtendImm(InstructionFetched[IMM_MSB:IMM_LSB]);

   register_file u_register_file (
      .ClockInput  (ClockInput),
      .ResetN      (ResetN),
      .ReadAddrB   (regB),
      .ReadAddrC   (regC),
      .ReadAddrA   (regA),
      .ReadDataB   (dataB),
      .ReadDataC   (dataC),
      .ReadDataA   (dataA),
      .WriteEnable (WB_WriteEnable),
      .WriteAddr   (WB_WriteReg),
      .WriteData   (WB_WriteData)
   );

   always_comb begin
      useA = (opcode == OP_STORE) || (opcode == OP_BEQ);
      useB = (opcode == OP_ALU) || (opcode == OP_ADDI) || (opcode == OP_LOAD) ||
             (opcode == OP_STORE) || (opcode == OP_BEQ);
      useC = (opcode == OP_ALU);
   end

   always_comb begin
      loadUseStall = EX_MemRead && (EX_DestReg != 4'd0) &&
                     ((useA && (regA == EX_DestReg)) ||
                      (useB && (regB == EX_DestReg)) ||
                      (useC && (regC == EX_DestReg)));
      // BEQ compares in decode, so it must wait for any in-flight producer of its sources.
      branchStall = (opcode == OP_BEQ) &&
                    (((regA != 4'd0) && ((EX_RegWrite && (regA == EX_DestReg)) ||
                                         (MEM_RegWrite && (regA == MEM_DestReg)))) ||
                     ((regB != 4'd0) && ((EX_RegWrite && (regB == EX_DestReg)) ||
                                         (MEM_RegWrite && (regB == MEM_DestReg)))));
      stall = loadUseStall || branchStall;
   end

   assign branchTaken     = (opcode == OP_JMP) || ((opcode == OP_BEQ) && (dataA == dataB));
   assign IF_StallReq     = ResetN && stall;
   assign BranchSelection = ResetN && !stall && branchTaken;
   assign BranchAddress   = (opcode == OP_JMP) ? {12'b0, InstructionFetched[IMM_MSB:IMM_LSB]}
                                               : ProgramCounter + immediate;

   always_comb begin
      nextIdex = BUBBLE;
      if (!stall) begin
         case (opcode)
            OP_ALU: begin
               nextIdex.opcode    = opcode;
               nextIdex.destReg   = regA;
               nextIdex.operandA  = dataB;
               nextIdex.operandB  = dataC;
               nextIdex.immediate = immediate;
               nextIdex.regWrite  = 1'b1;
            end
            OP_ADDI: begin
               nextIdex.opcode    = opcode;
               nextIdex.destReg   = regA;
               nextIdex.operandA  = dataB;
               nextIdex.immediate = immediate;
               nextIdex.regWrite  = 1'b1;
            end
            OP_LOAD: begin
               nextIdex.opcode    = opcode;
               nextIdex.destReg   = regA;
               nextIdex.operandA  = dataB;
               nextIdex.immediate = immediate;
               nextIdex.regWrite  = 1'b1;
               nextIdex.memRead   = 1'b1;
            end
            OP_STORE: begin
               nextIdex.opcode    = opcode;
               nextIdex.operandA  = dataB;
               nextIdex.operandB  = dataA;
               nextIdex.immediate = immediate;
               nextIdex.memWrite  = 1'b1;
            end
            default: begin
               nextIdex = BUBBLE;
            end
         endcase
      end
   end

   always_ff @(posedge ClockInput or negedge ResetN) begin
      if (!ResetN) begin
         idexQ <= BUBBLE;
      end else begin
         idexQ <= nextIdex;
      end
   end

   assign ID_Opcode    = idexQ.opcode;
   assign ID_DestReg   = idexQ.destReg;
   assign ID_OperandA  = idexQ.operandA;
   assign ID_OperandB  = idexQ.operandB;
   assign ID_Immediate = idexQ.immediate;
   assign ID_RegWrite  = idexQ.regWrite;
   assign ID_MemRead   = idexQ.memRead;
   assign ID_MemWrite  = idexQ.memWrite;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - directed self-checking bench for instruction_decode_stage
module tb_instruction_decode_stage;

   logic        ClockInput = 1'b0;
   logic        ResetN;
   logic [31:0] InstructionFetched;
   logic [31:0] ProgramCounter;
   logic        WB_WriteEnable;
   logic [3:0]  WB_WriteReg;
   logic [31:0] WB_WriteData;
   logic        EX_RegWrite;
   logic        EX_MemRead;
   logic [3:0]  EX_DestReg;
   logic        MEM_RegWrite;
   logic [3:0]  MEM_DestReg;
   logic        BranchSelection;
   logic [31:0] BranchAddress;
   logic        IF_StallReq;
   logic [3:0]  ID_Opcode;
   logic [3:0]  ID_DestReg;
   logic [31:0] ID_OperandA;
   logic [31:0] ID_OperandB;
   logic [31:0] ID_Immediate;
   logic        ID_RegWrite;
   logic        ID_MemRead;
   logic        ID_MemWrite;

   int errors = 0;
   int checks = 0;

   always #5 ClockInput = ~ClockInput;

   instruction_decode_stage dut (
      .ClockInput         (ClockInput),
      .ResetN             (ResetN),
      .InstructionFetched (InstructionFetched),
      .ProgramCounter     (ProgramCounter),
      .WB_WriteEnable     (WB_WriteEnable),
      .WB_WriteReg        (WB_WriteReg),
      .WB_WriteData       (WB_WriteData),
      .EX_RegWrite        (EX_RegWrite),
      .EX_MemRead         (EX_MemRead),
      .EX_DestReg         (EX_DestReg),
      .MEM_RegWrite       (MEM_RegWrite),
      .MEM_DestReg        (MEM_DestReg),
      .BranchSelection    (BranchSelection),
      .BranchAddress      (BranchAddress),
      .IF_StallReq        (IF_StallReq),
      .ID_Opcode          (ID_Opcode),
      .ID_DestReg         (ID_DestReg),
      .ID_OperandA        (ID_OperandA),
      .ID_OperandB        (ID_OperandB),
      .ID_Immediate       (ID_Immediate),
      .ID_RegWrite        (ID_RegWrite),
      .ID_MemRead         (ID_MemRead),
      .ID_MemWrite        (ID_MemWrite)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkIdex(input string tag, input logic [3:0] op, input logic [3:0] dest,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                            input logic rw, input logic mr, input logic mw);
      check({tag, ".opcode"}, {28'd0, ID_Opcode}, {28'd0, op});
      check({tag, ".dest"}, {28'd0, ID_DestReg}, {28'd0, dest});
      check({tag, ".opA"}, ID_OperandA, a);
      check({tag, ".opB"}, ID_OperandB, b);
      check({tag, ".imm"}, ID_Immediate, imm);
      check({tag, ".ctl"}, {29'd0, ID_RegWrite, ID_MemRead, ID_MemWrite}, {29'd0, rw, mr, mw});
   endtask

   task automatic checkBubble(input string tag);
      checkIdex(tag, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkFetch(input string tag, input logic sel, input logic stall);
      check({tag, ".branchSel"}, {31'd0, BranchSelection}, {31'd0, sel});
      check({tag, ".stallReq"}, {31'd0, IF_StallReq}, {31'd0, stall});
   endtask

   task automatic tick();
      @(posedge ClockInput);
      @(negedge ClockInput);
   endtask

   task automatic clearSide();
      WB_WriteEnable = 1'b0;
      WB_WriteReg    = 4'd0;
      WB_WriteData   = 32'd0;
      EX_RegWrite    = 1'b0;
      EX_MemRead     = 1'b0;
      EX_DestReg     = 4'd0;
      MEM_RegWrite   = 1'b0;
      MEM_DestReg    = 4'd0;
   endtask

   task automatic wbWrite(input logic [3:0] r, input logic [31:0] d);
      InstructionFetched = 32'd0;
      WB_WriteEnable = 1'b1;
      WB_WriteReg    = r;
      WB_WriteData   = d;
      tick();
      clearSide();
   endtask

   initial begin
      ResetN = 1'b0;
      InstructionFetched = 32'd0;
      ProgramCounter = 32'd0;
      clearSide();
      tick();
      tick();
      #1;
      checkBubble("reset");
      checkFetch("reset", 1'b0, 1'b0);
      ResetN = 1'b1;
      tick();

      // R5 = 55, then ADDI R6 <- R5 + 0
      wbWrite(4'd5, 32'd55);
      InstructionFetched = 32'h26500000;
      #1;
      checkFetch("addi_r5", 1'b0, 1'b0);
      tick();
      checkIdex("addi_r5", 4'd2, 4'd6, 32'd55, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

      // BEQ R3,R4,-4 at PC=4, both equal 7 -> target 0
      wbWrite(4'd3, 32'd7);
      wbWrite(4'd4, 32'd7);
      InstructionFetched = 32'h434FFFFC;
      ProgramCounter = 32'd4;
      #1;
      checkFetch("beq_taken", 1'b1, 1'b0);
      check("beq_taken.addr", BranchAddress, 32'h0000_0000);
      tick();
      checkBubble("beq_taken");

      // BEQ R3,R5: 7 != 55 -> not taken
      InstructionFetched = 32'h43500010;
      ProgramCounter = 32'd100;
      #1;
      checkFetch("beq_nottaken", 1'b0, 1'b0);
      tick();
      checkBubble("beq_nottaken");

      // Load-use: ALU R1 <- R2 op R3 while EX loads R2
      InstructionFetched = 32'h11230000;
      EX_MemRead = 1'b1;
      EX_DestReg = 4'd2;
      #1;
      checkFetch("loaduse", 1'b0, 1'b1);
      tick();
      checkBubble("loaduse");
      clearSide();
      #1;
      checkFetch("loaduse_resume", 1'b0, 1'b0);
      tick();
      checkIdex("loaduse_resume", 4'd1, 4'd1, 32'd0, 32'd7, 32'h0003_0000, 1'b1, 1'b0, 1'b0);

      // Load into R0 never stalls
      EX_MemRead = 1'b1;
      EX_DestReg = 4'd0;
      InstructionFetched = 32'h31000004;
      #1;
      checkFetch("load_r0_dest", 1'b0, 1'b0);
      tick();
      checkIdex("load", 4'd3, 4'd1, 32'd0, 32'd0, 32'd4, 1'b1, 1'b1, 1'b0);
      clearSide();

      // Write-through: WB writes R1=9 while ADDI R2 <- R1 + 5 reads it
      InstructionFetched = 32'h22100005;
      WB_WriteEnable = 1'b1;
      WB_WriteReg = 4'd1;
      WB_WriteData = 32'd9;
      tick();
      clearSide();
      checkIdex("writethrough", 4'd2, 4'd2, 32'd9, 32'd0, 32'd5, 1'b1, 1'b0, 1'b0);

      // Writes to R0 are ignored, including the bypass
      InstructionFetched = 32'h22000000;
      WB_WriteEnable = 1'b1;
      WB_WriteReg = 4'd0;
      WB_WriteData = 32'd123;
      tick();
      clearSide();
      check("r0_write.opA", ID_OperandA, 32'd0);

      // JMP 2, with an EX writer present: never stalls
      InstructionFetched = 32'h50000002;
      EX_RegWrite = 1'b1;
      EX_DestReg = 4'd3;
      #1;
      checkFetch("jmp", 1'b1, 1'b0);
      check("jmp.addr", BranchAddress, 32'd2);
      tick();
      checkBubble("jmp");
      clearSide();

      // BEQ R3,R4,+8 at PC=10 behind EX then MEM producers of R3
      InstructionFetched = 32'h43400008;
      ProgramCounter = 32'd10;
      EX_RegWrite = 1'b1;
      EX_DestReg = 4'd3;
      #1;
      checkFetch("beq_stall1", 1'b0, 1'b1);
      tick();
      checkBubble("beq_stall1");
      clearSide();
      MEM_RegWrite = 1'b1;
      MEM_DestReg = 4'd3;
      #1;
      checkFetch("beq_stall2", 1'b0, 1'b1);
      tick();
      checkBubble("beq_stall2");
      clearSide();
      #1;
      checkFetch("beq_resolve", 1'b1, 1'b0);
      check("beq_resolve.addr", BranchAddress, 32'd18);
      tick();

      // STORE R4 -> mem[R1 + 16]
      InstructionFetched = 32'h64100010;
      tick();
      checkIdex("store", 4'd6, 4'd0, 32'd9, 32'd7, 32'd16, 1'b0, 1'b0, 1'b1);

      // Opcode 9 acts as NOP
      InstructionFetched = 32'h9123FFFF;
      tick();
      checkBubble("op9");

      // Reset asserted mid-stall
      InstructionFetched = 32'h64100010;
      tick();
      InstructionFetched = 32'h22100000;
      EX_MemRead = 1'b1;
      EX_DestReg = 4'd1;
      #1;
      checkFetch("prereset", 1'b0, 1'b1);
      ResetN = 1'b0;
      #1;
      checkFetch("midreset", 1'b0, 1'b0);
      checkBubble("midreset");
      tick();
      clearSide();
      ResetN = 1'b1;
      InstructionFetched = 32'h26500000;
      tick();
      checkIdex("r5_after_reset", 4'd2, 4'd6, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
